// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-stage and memory handshakes of the memory port arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage,
// with a fetch starvation guard and a timeout for a memory that never answers.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_is_d_q, owner_is_d_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [STK_W-1:0]  d_streak_q, d_streak_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              d_req;
    logic              i_wins;
    logic [STK_W-1:0]  d_streak_inc;
    logic              finish;
    logic [DATA_W-1:0] finish_data;

    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tmo_cnt_d    = tmo_cnt_q;
        d_streak_d   = d_streak_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        err_d        = 1'b0;
        if_rdata_d   = '0;
        dm_rdata_d   = '0;
        finish       = 1'b0;
        finish_data  = '0;

        d_req  = bus.dm_read | bus.dm_write;
        i_wins = bus.if_req & (~d_req | (d_streak_q == STK_W'(MAX_D_STREAK)));
        // A D grant only counts toward the streak while fetch is actually waiting.
        if (!bus.if_req)
            d_streak_inc = '0;
        else if (d_streak_q == STK_W'(MAX_D_STREAK))
            d_streak_inc = d_streak_q;
        else
            d_streak_inc = d_streak_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.dm_read && bus.dm_write) begin
                    state_d      = DONE;
                    owner_is_d_d = 1'b1;
                    dm_ack_d     = 1'b1;
                    err_d        = 1'b1;
                    d_streak_d   = d_streak_inc;
                end else if (i_wins) begin
                    state_d      = BUSY;
                    owner_is_d_d = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    mem_wdata_d  = '0;
                    tmo_cnt_d    = '0;
                    d_streak_d   = '0;
                end else if (d_req) begin
                    state_d      = BUSY;
                    owner_is_d_d = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_we_d     = bus.dm_write;
                    mem_addr_d   = bus.dm_addr;
                    mem_wdata_d  = bus.dm_wdata;
                    tmo_cnt_d    = '0;
                    d_streak_d   = d_streak_inc;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    finish      = 1'b1;
                    finish_data = mem_we_q ? '0 : bus.mem_rdata;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 2)) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d   = DONE;
                    mem_en_d  = 1'b0;
                    tmo_cnt_d = '0;
                    if (owner_is_d_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = finish_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = finish_data;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_is_d_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tmo_cnt_q    <= '0;
            d_streak_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
            d_streak_q   <= d_streak_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.err       = err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
endmodule
